// File: rtl/decrypt_sequencer_pkg.sv
// rtl/decrypt_sequencer_pkg.sv - shared encodings, defaults and helpers for the decrypt sequencer
package decrypt_sequencer_pkg;

    localparam int BUF_LEN_DEFAULT      = 108;
    localparam int RESULT_BASE_DEFAULT  = 1500;
    localparam int EXEC_TIMEOUT_DEFAULT = 1 << 20;

    // Processor enable encodings seen by the integration (2'b11 is never driven)
    localparam logic [1:0] CPU_IDLE  = 2'b00;
    localparam logic [1:0] CPU_WRITE = 2'b01;
    localparam logic [1:0] CPU_EXEC  = 2'b10;

    // Per-character buffer write phases
    localparam logic [1:0] WS_LOAD = 2'b00;
    localparam logic [1:0] WS_HOLD = 2'b01;
    localparam logic [1:0] WS_ADV  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FILL    = 3'd1;
    localparam state_t ST_WR_HOLD = 3'd2;
    localparam state_t ST_WR_ADV  = 3'd3;
    localparam state_t ST_EXEC    = 3'd4;
    localparam state_t ST_RD_ADDR = 3'd5;
    localparam state_t ST_RD_WAIT = 3'd6;
    localparam state_t ST_RD_OUT  = 3'd7;

    // Bits needed to hold any value 0..max_value
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    // Readback address, wrapping modulo the 4096-word RAM
    function automatic logic [11:0] readback_addr(input int base, input int index);
        return 12'(base + index);
    endfunction

endpackage

// File: rtl/decrypt_sequencer_seq_counter.sv
// rtl/decrypt_sequencer_seq_counter.sv - clear/enable up-counter with terminal-count compare
module seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    // Clear wins over enable so a new job always starts from zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/decrypt_sequencer.sv
// rtl/decrypt_sequencer.sv - streams a ciphertext job into the processor buffer, runs it, reads plaintext back
module decrypt_sequencer
    import decrypt_sequencer_pkg::*;
#(
    parameter int BUF_LEN      = BUF_LEN_DEFAULT,
    parameter int RESULT_BASE  = RESULT_BASE_DEFAULT,
    parameter int EXEC_TIMEOUT = EXEC_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        done,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  char_buffer_data,
    output logic [1:0]  cpu_en,
    output logic [1:0]  wrstate,
    output logic [11:0] read_addr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CHAR_W = cnt_width(BUF_LEN);
    localparam int TMO_W  = cnt_width(EXEC_TIMEOUT - 1);

    state_t              state;
    logic [CHAR_W-1:0]   char_cnt;
    logic [CHAR_W-1:0]   idx_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                char_last;
    logic                idx_last;
    logic                tmo_last;
    logic                start_job;
    logic                out_fire;
    logic                unused_bits;

    assign start_job = (state == ST_IDLE) && start;
    assign out_fire  = (state == ST_RD_OUT) && out_valid && out_ready;

    // Only the low byte of each result word carries plaintext
    assign unused_bits = ^{mem_rdata[31:8], char_cnt, tmo_cnt};

    seq_counter #(.WIDTH(CHAR_W)) u_char_cnt (
        .clock       (clock),
        .reset       (reset),
        .clear       (start_job),
        .enable      (state == ST_WR_ADV),
        .terminal    (CHAR_W'(BUF_LEN - 1)),
        .count       (char_cnt),
        .at_terminal (char_last)
    );

    seq_counter #(.WIDTH(CHAR_W)) u_idx_cnt (
        .clock       (clock),
        .reset       (reset),
        .clear       (start_job || ((state == ST_EXEC) && done)),
        .enable      (out_fire),
        .terminal    (CHAR_W'(BUF_LEN - 1)),
        .count       (idx_cnt),
        .at_terminal (idx_last)
    );

    seq_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
        .clock       (clock),
        .reset       (reset),
        .clear       (start_job),
        .enable      ((state == ST_EXEC) && !done),
        .terminal    (TMO_W'(EXEC_TIMEOUT - 1)),
        .count       (tmo_cnt),
        .at_terminal (tmo_last)
    );

    // Job sequencing; read_addr is loaded one state ahead so it is valid throughout RD_ADDR
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            char_buffer_data <= 8'h00;
            read_addr        <= 12'h000;
            out_data         <= 8'h00;
            out_valid        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_FILL;
                        timeout_err <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (rx_valid) begin
                        char_buffer_data <= rx_data;
                        state            <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    state <= ST_WR_ADV;
                end
                ST_WR_ADV: begin
                    state <= char_last ? ST_EXEC : ST_FILL;
                end
                ST_EXEC: begin
                    if (done) begin
                        state     <= ST_RD_ADDR;
                        read_addr <= readback_addr(RESULT_BASE, 0);
                    end else if (tmo_last) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    out_data  <= mem_rdata[7:0];
                    out_valid <= 1'b1;
                    state     <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx_last) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_RD_ADDR;
                            read_addr <= readback_addr(RESULT_BASE, int'(idx_cnt) + 1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Mode outputs decode straight from the state register
    always_comb begin
        cpu_en   = CPU_IDLE;
        wrstate  = WS_LOAD;
        rx_ready = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_FILL: begin
                cpu_en   = CPU_WRITE;
                rx_ready = 1'b1;
            end
            ST_WR_HOLD: begin
                cpu_en  = CPU_WRITE;
                wrstate = WS_HOLD;
            end
            ST_WR_ADV: begin
                cpu_en  = CPU_WRITE;
                wrstate = WS_ADV;
            end
            ST_EXEC: begin
                cpu_en = CPU_EXEC;
            end
            default: begin
                cpu_en = CPU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decrypt_sequencer.sv
// tb/tb_decrypt_sequencer.sv - directed self-checking bench for decrypt_sequencer
module tb_decrypt_sequencer;

    localparam int BUF_LEN      = 108;
    localparam int RESULT_BASE  = 1500;
    localparam int EXEC_TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        done;
    logic [31:0] mem_rdata;
    logic [7:0]  char_buffer_data;
    logic [1:0]  cpu_en;
    logic [1:0]  wrstate;
    logic [11:0] read_addr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;

    int   total = 0;
    int   passed = 0;
    logic mem_mode = 1'b0;

    int         cyc = 0;
    int         wradv_cnt = 0;
    int         seq_err = 0;
    int         rdy_err = 0;
    int         hold_err = 0;
    int         exec_cyc_cnt = 0;
    int         valid_cyc = 0;
    int         out_cnt = 0;
    logic [1:0] prev_ws = 2'b00;
    logic [7:0] hold_val = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0]  char_log [0:1023];
    logic [7:0]  out_log  [0:1023];
    logic [11:0] addr_log [0:1023];
    logic [7:0]  sent     [0:BUF_LEN-1];

    decrypt_sequencer #(
        .BUF_LEN      (BUF_LEN),
        .RESULT_BASE  (RESULT_BASE),
        .EXEC_TIMEOUT (EXEC_TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .done             (done),
        .mem_rdata        (mem_rdata),
        .char_buffer_data (char_buffer_data),
        .cpu_en           (cpu_en),
        .wrstate          (wrstate),
        .read_addr        (read_addr),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous RAM: result window returns 0x61 (mode 0) or an address-derived byte (mode 1)
    always @(posedge clock) begin
        if (read_addr >= 12'd1500 && read_addr < 12'd1608) begin
            if (mem_mode) mem_rdata <= {24'hA5C3F0, 8'(read_addr - 12'd1500) + 8'h10};
            else          mem_rdata <= 32'h0000_0061;
        end else begin
            mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    // Protocol monitor sampled on the falling edge
    always @(negedge clock) begin
        if (!reset) begin
            prev_ws    <= 2'b00;
            prev_stall <= 1'b0;
        end else begin
            prev_ws <= wrstate;
            if (wrstate == 2'b10) begin
                if (wradv_cnt < 1024) char_log[wradv_cnt] <= char_buffer_data;
                wradv_cnt <= wradv_cnt + 1;
                if (prev_ws != 2'b01 || char_buffer_data != hold_val) seq_err <= seq_err + 1;
            end
            if (wrstate == 2'b01) begin
                hold_val <= char_buffer_data;
                if (prev_ws != 2'b00 || cpu_en != 2'b01) seq_err <= seq_err + 1;
            end
            if (wrstate == 2'b00 && prev_ws == 2'b01) seq_err <= seq_err + 1;
            if (wrstate == 2'b11 || cpu_en == 2'b11) seq_err <= seq_err + 1;
            if (rx_ready != (cpu_en == 2'b01 && wrstate == 2'b00)) rdy_err <= rdy_err + 1;
            if (cpu_en == 2'b10) exec_cyc_cnt <= exec_cyc_cnt + 1;
            if (out_valid) valid_cyc <= valid_cyc + 1;
            if (out_valid && out_ready) begin
                if (out_cnt < 1024) begin
                    out_log[out_cnt]  <= out_data;
                    addr_log[out_cnt] <= read_addr;
                end
                out_cnt <= out_cnt + 1;
            end
            if (prev_stall && (!out_valid || out_data != stall_data)) hold_err <= hold_err + 1;
            prev_stall <= out_valid && !out_ready;
            stall_data <= out_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 0);
        check({tag, "_wrstate"}, 32'(wrstate), 0);
        check({tag, "_char"}, 32'(char_buffer_data), 0);
        check({tag, "_read_addr"}, 32'(read_addr), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Offer one byte after an optional idle gap; returns just after the accepting edge
    task automatic send_char(input logic [7:0] b, input int gap, output int xfer_cyc);
        int guard;
        if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = ~b;
            repeat (gap) @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard = 0;
        while (!rx_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("rx_ready_timeout", 0, 1);
        xfer_cyc = cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_exec(input string tag, output int at);
        int guard = 0;
        while (cpu_en != 2'b10 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check(tag, 32'(cpu_en), 2);
        at = cyc;
    endtask

    task automatic wait_outs(input string tag, input int target);
        int guard = 0;
        while (out_cnt < target && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        check(tag, out_cnt, target);
    endtask

    initial begin
        int t, first_xfer, bad, guard;
        int b_adv, b_out, b_exec, b_valid;
        logic [7:0]  s_data;
        logic [11:0] s_addr;

        reset = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        done = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", 32'(busy), 0);

        // Job 1: back-to-back bytes, done after 50 EXEC cycles, readback with a stall at index 5
        b_adv = wradv_cnt; b_out = out_cnt;
        start = 1'b1;
        for (int i = 0; i < BUF_LEN; i++) begin
            send_char(8'(8'h41 + i), 0, t);
            if (i == 0) begin
                first_xfer = t;
                start = 1'b0;
            end
        end
        wait_exec("job1_exec", t);
        check("job1_throughput", t - first_xfer, 3 * BUF_LEN);
        check("job1_wradv", wradv_cnt - b_adv, BUF_LEN);
        bad = 0;
        for (int i = 0; i < BUF_LEN; i++) if (char_log[b_adv + i] !== 8'(8'h41 + i)) bad++;
        check("job1_chars", bad, 0);
        rx_valid = 1'b0;
        repeat (49) @(negedge clock);
        check("job1_exec_hold", 32'(cpu_en), 2);
        out_ready = 1'b1;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        wait_outs("job1_first5", b_out + 5);
        @(posedge clock); #1;
        out_ready = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("stall_valid", 32'(out_valid), 1);
        s_data = out_data; s_addr = read_addr; bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (!out_valid || out_data !== s_data || read_addr !== s_addr || out_cnt != b_out + 5) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_addr", 32'(s_addr), 1505);
        check("stall_data", 32'(s_data), 32'h61);
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_outs("job1_outs", b_out + BUF_LEN);
        @(negedge clock);
        check("job1_end_busy", 32'(busy), 0);
        check("job1_end_cpu_en", 32'(cpu_en), 0);
        check("job1_end_valid", 32'(out_valid), 0);
        check("job1_end_tmo", 32'(timeout_err), 0);
        bad = 0;
        for (int i = 0; i < BUF_LEN; i++) begin
            if (out_log[b_out + i] !== 8'h61) bad++;
            if (addr_log[b_out + i] !== 12'(RESULT_BASE + i)) bad++;
        end
        check("job1_readback", bad, 0);

        // Job 2: random gaps, done never arrives -> timeout abort
        b_adv = wradv_cnt; b_exec = exec_cyc_cnt; b_valid = valid_cyc;
        start = 1'b1;
        for (int i = 0; i < BUF_LEN; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            send_char(sent[i], int'($urandom_range(0, 3)), t);
            if (i == 0) start = 1'b0;
        end
        rx_valid = 1'b0;
        guard = 0;
        while (busy && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        check("tmo_busy", 32'(busy), 0);
        check("tmo_flag", 32'(timeout_err), 1);
        check("tmo_exec_cycles", exec_cyc_cnt - b_exec, EXEC_TIMEOUT);
        check("tmo_no_readback", valid_cyc - b_valid, 0);
        check("tmo_wradv", wradv_cnt - b_adv, BUF_LEN);
        bad = 0;
        for (int i = 0; i < BUF_LEN; i++) if (char_log[b_adv + i] !== sent[i]) bad++;
        check("tmo_chars", bad, 0);

        // Job 3: reset during WR_HOLD of character 40
        b_adv = wradv_cnt;
        start = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            send_char(8'(8'h20 + i), 0, t);
            if (i == 0) start = 1'b0;
        end
        check("mid_tmo_cleared", 32'(timeout_err), 0);
        check("mid_wrstate", 32'(wrstate), 1);
        check("mid_wradv", wradv_cnt - b_adv, 40);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        rx_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Job 4: fresh job after reset, done held high during FILL must be ignored
        mem_mode = 1'b1;
        b_adv = wradv_cnt; b_out = out_cnt;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < BUF_LEN; i++) begin
            send_char(8'(8'h80 + i), 0, t);
            if (i == 0) begin
                start = 1'b0;
                done  = 1'b1;
            end
        end
        done = 1'b0;
        rx_valid = 1'b0;
        wait_exec("job4_exec", t);
        check("job4_wradv", wradv_cnt - b_adv, BUF_LEN);
        bad = 0;
        for (int i = 0; i < BUF_LEN; i++) if (char_log[b_adv + i] !== 8'(8'h80 + i)) bad++;
        check("job4_chars", bad, 0);
        repeat (5) @(negedge clock);
        check("job4_exec_hold", 32'(cpu_en), 2);
        out_ready = 1'b1;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        wait_outs("job4_outs", b_out + BUF_LEN);
        @(negedge clock);
        check("job4_end_busy", 32'(busy), 0);
        bad = 0;
        for (int i = 0; i < BUF_LEN; i++) begin
            if (out_log[b_out + i] !== 8'(8'h10 + i)) bad++;
            if (addr_log[b_out + i] !== 12'(RESULT_BASE + i)) bad++;
        end
        check("job4_readback", bad, 0);

        check("wrstate_sequence", seq_err, 0);
        check("rx_ready_rule", rdy_err, 0);
        check("out_hold_rule", hold_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decrypt_sequencer.md
DECRYPT_SEQUENCER -- requirements
Module: decrypt_sequencer

Interface
REQ-001 Parameter BUF_LEN, default 108, characters per job (12x9 buffer).
REQ-002 Parameter RESULT_BASE, default 1500, first RAM word address read back after execution.
REQ-003 Parameter EXEC_TIMEOUT, default 2^20, maximum EXEC cycles before abort.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a job; sampled only in IDLE.
REQ-007 rx_data  in  8  incoming ciphertext character.
REQ-008 rx_valid / rx_ready  in / out  1 / 1  character handshake; transfer when both high.
REQ-009 done  in  1  processor-finished flag (reg28 == 1 indication).
REQ-010 mem_rdata  in  32  RAM read data, valid one cycle after read_addr is presented.
REQ-011 char_buffer_data  out  8  character presented for buffer write.
REQ-012 cpu_en  out  2  00 IDLE, 01 WRITE, 10 EXEC; 11 never driven.
REQ-013 wrstate  out  2  per-character write phase: 00 load, 01 hold, 10 advance.
REQ-014 read_addr  out  12  RAM readback address.
REQ-015 out_data / out_valid / out_ready  out / out / in  8 / 1 / 1  plaintext stream; transfer when valid and ready both high.
REQ-016 busy / timeout_err  out  1 / 1  job in progress / last job aborted on timeout.

Function
REQ-017 States SHALL be IDLE, FILL, WR_HOLD, WR_ADV, EXEC, RD_ADDR, RD_WAIT, RD_OUT.
REQ-018 IDLE: cpu_en=00; start=1 -> FILL, clear char and cycle counters, clear timeout_err.
REQ-019 FILL: cpu_en=01, wrstate=00, rx_ready=1; on transfer latch rx_data into char_buffer_data -> WR_HOLD.
REQ-020 WR_HOLD: cpu_en=01, wrstate=01, char_buffer_data stable, rx_ready=0; exactly one cycle -> WR_ADV.
REQ-021 WR_ADV: cpu_en=01, wrstate=10 for exactly one cycle; char count +1; count==BUF_LEN -> EXEC, else -> FILL.
REQ-022 The sequencer SHALL issue exactly BUF_LEN WR_ADV cycles per job, never more.
REQ-023 EXEC: cpu_en=10; done=1 -> RD_ADDR with readback index 0; cycle counter reaching EXEC_TIMEOUT-1 without done -> IDLE with timeout_err=1.
REQ-024 done SHALL be ignored outside EXEC.
REQ-025 RD_ADDR: cpu_en=00, read_addr=RESULT_BASE+index (12-bit, wraps mod 4096) -> RD_WAIT.
REQ-026 RD_WAIT: one cycle for synchronous RAM latency; then capture mem_rdata[7:0] into out_data, out_valid=1 -> RD_OUT.
REQ-027 RD_OUT: out_data/out_valid held stable until out_ready; on transfer index +1; index==BUF_LEN -> IDLE, else -> RD_ADDR.
REQ-028 rx_ready SHALL be 0 in every state except FILL; rx_valid outside FILL is not consumed.
REQ-029 start while busy SHALL be ignored.
REQ-030 busy=1 in every state except IDLE.
REQ-031 Minimum write throughput: 3 cycles per character with rx_valid held high.

Reset
REQ-032 reset low SHALL immediately force IDLE, cpu_en=00, wrstate=00, char_buffer_data=0, read_addr=0, out_data=0, out_valid=0, rx_ready=0, busy=0, timeout_err=0, all counters 0.
REQ-033 Reset asserted mid-job SHALL abandon the job; no partial output transfer completes after release.

Structure
REQ-034 cpu_en encodings, wrstate encodings, state enum, BUF_LEN and RESULT_BASE defaults SHALL live in a shared package, also used by the top-level integration.
REQ-035 One sub-module SHALL be natural: seq_counter (width-parameterised clear/enable/terminal-count counter), instantiated for char count, readback index and exec timeout.

Verification
REQ-036 Reset then start, 108 bytes 0x41.. streamed with rx_valid always high -> 108 WR_ADV pulses, each wrstate 00->01->10, then cpu_en=10.
REQ-037 rx_valid gapped randomly during FILL -> char_buffer_data stable throughout every WR_HOLD, WR_ADV count still 108.
REQ-038 done pulsed 50 cycles into EXEC, mem model returning 0x00000061 at 1500..1607 -> 108 out transfers of 0x61, read_addr 1500..1607 in order, then IDLE, busy=0.
REQ-039 out_ready held low 20 cycles at index 5 -> out_data/out_valid unchanged, read_addr stays 1505, no index advance.
REQ-040 EXEC_TIMEOUT=64, done never asserted -> IDLE after 64 EXEC cycles, timeout_err=1, no readback.
REQ-041 reset low during WR_HOLD of char 40, then start and 108 new chars -> outputs at reset values immediately; new job completes normally.
